// File: rtl/input_feed_ctrl_if.sv
// Control/status bundle between a job requester and input_feed_ctrl.
// Also carries the controller's FSM state so checkers can observe it.
interface input_feed_ctrl_if #(
  parameter int LEN_W  = 8,
  parameter int TILE_W = 8
) ();
  // Handshake: start is a one-cycle request, accepted only while busy=0.
  // read is a strobe with no ready; stall is the only backpressure and
  // gates read in the same cycle. done pulses once per completed job.
  logic              start;
  logic              abort;
  logic              stall;
  logic [TILE_W-1:0] num_tiles;
  logic [LEN_W-1:0]  tile_len;
  logic              read;
  logic              busy;
  logic              done;
  logic              last_read;
  logic [TILE_W-1:0] tile_idx;
  logic [LEN_W-1:0]  row_idx;
  logic [2:0]        fsm_state;

  modport master (
    output start, abort, stall, num_tiles, tile_len,
    input  read, busy, done, last_read, tile_idx, row_idx, fsm_state
  );

  modport slave (
    input  start, abort, stall, num_tiles, tile_len,
    output read, busy, done, last_read, tile_idx, row_idx, fsm_state
  );
endinterface

// File: rtl/input_feed_ctrl.sv
// Sequences row-0 read strobes for a tiled job into the skewed input buffer,
// with inter-tile gaps and a drain period so the skewed valid chain empties.
module input_feed_ctrl #(
   parameter int SYS_ROWS   = 4,
   parameter int LEN_W      = 8,
   parameter int TILE_W     = 8,
   parameter int GAP_CYCLES = 2
) (
   input logic              clk,
   input logic              rst,
   input_feed_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FEED  = 3'd1,
      GAP   = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   // One down-counter serves both GAP and DRAIN; size it for the larger.
   localparam int CNT_MAX = (GAP_CYCLES > SYS_ROWS) ? GAP_CYCLES : SYS_ROWS;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   state_t            state;
   logic [TILE_W-1:0] tiles_q;
   logic [LEN_W-1:0]  len_q;
   logic [TILE_W-1:0] tile_q;
   logic [LEN_W-1:0]  row_q;
   logic [CNT_W-1:0]  cnt;
   logic              busy_q;
   logic              done_q;

   logic read_s;
   logic row_last;
   logic tile_last;

   assign read_s    = (state == FEED) && !bus.stall && !bus.abort;
   assign row_last  = (row_q == len_q - LEN_W'(1));
   assign tile_last = (tile_q == tiles_q - TILE_W'(1));

   assign bus.read      = read_s;
   assign bus.last_read = read_s && row_last && tile_last;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.tile_idx  = tile_q;
   assign bus.row_idx   = row_q;
   assign bus.fsm_state = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         tiles_q <= '0;
         len_q   <= '0;
         tile_q  <= '0;
         row_q   <= '0;
         cnt     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else if (state != IDLE && bus.abort) begin
         state  <= IDLE;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  tiles_q <= bus.num_tiles;
                  len_q   <= bus.tile_len;
                  tile_q  <= '0;
                  row_q   <= '0;
                  busy_q  <= 1'b1;
                  // An empty job completes without ever touching the FIFO.
                  if (bus.num_tiles == '0 || bus.tile_len == '0) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                  end else begin
                     state <= FEED;
                  end
               end
            end
            FEED: begin
               if (read_s) begin
                  if (row_last) begin
                     row_q <= '0;
                     if (tile_last) begin
                        if (SYS_ROWS > 1) begin
                           state <= DRAIN;
                           cnt   <= CNT_W'(SYS_ROWS - 2);
                        end else begin
                           state  <= DONE;
                           done_q <= 1'b1;
                        end
                     end else begin
                        tile_q <= tile_q + TILE_W'(1);
                        if (GAP_CYCLES > 0) begin
                           state <= GAP;
                           cnt   <= CNT_W'(GAP_CYCLES - 1);
                        end
                     end
                  end else begin
                     row_q <= row_q + LEN_W'(1);
                  end
               end
            end
            GAP: begin
               if (cnt == '0) state <= FEED;
               else           cnt   <= cnt - CNT_W'(1);
            end
            DRAIN: begin
               if (cnt == '0) begin
                  state  <= DONE;
                  done_q <= 1'b1;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            DONE: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_input_feed_ctrl.sv
// Bench for input_feed_ctrl: read-count job model checked every cycle,
// plus directed jobs with hand-computed per-cycle patterns.
module tb_input_feed_ctrl;

  localparam int SYS_ROWS = 4;
  localparam int GAP      = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  input_feed_ctrl_if #(.LEN_W(8), .TILE_W(8)) bus  ();
  input_feed_ctrl_if #(.LEN_W(8), .TILE_W(8)) bus0 ();

  input_feed_ctrl #(.SYS_ROWS(SYS_ROWS), .LEN_W(8), .TILE_W(8), .GAP_CYCLES(GAP)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Second instance: no inter-tile gap and a single row, so no drain either.
  input_feed_ctrl #(.SYS_ROWS(1), .LEN_W(8), .TILE_W(8), .GAP_CYCLES(0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  assign bus0.start     = bus.start;
  assign bus0.abort     = bus.abort;
  assign bus0.stall     = bus.stall;
  assign bus0.num_tiles = bus.num_tiles;
  assign bus0.tile_len  = bus.tile_len;

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: a job is tiles*len reads, a gap after each non-final tile,
  // SYS_ROWS-1 drain cycles after the last read, then one done cycle
  int m_phase = 0;  // 0 idle, 1 running, 2 done cycle
  int m_tiles = 0;
  int m_len   = 0;
  int m_total = 0;
  int m_reads = 0;
  int m_gap   = 0;
  int m_drain = 0;

  always @(posedge clk or posedge rst) begin
    int n_phase, n_tiles, n_len, n_total, n_reads, n_gap, n_drain;
    if (rst) begin
      m_phase <= 0; m_tiles <= 0; m_len <= 0; m_total <= 0;
      m_reads <= 0; m_gap <= 0; m_drain <= 0;
    end else begin
      n_phase = m_phase; n_tiles = m_tiles; n_len = m_len; n_total = m_total;
      n_reads = m_reads; n_gap = m_gap; n_drain = m_drain;
      if (m_phase == 0) begin
        if (bus.start) begin
          n_tiles = int'(bus.num_tiles);
          n_len   = int'(bus.tile_len);
          n_total = n_tiles * n_len;
          n_reads = 0; n_gap = 0; n_drain = 0;
          n_phase = (n_total == 0) ? 2 : 1;
        end
      end else if (m_phase == 1) begin
        if (bus.abort) n_phase = 0;
        else if (m_gap > 0) n_gap = m_gap - 1;
        else if (m_reads == m_total) begin
          n_drain = m_drain - 1;
          if (n_drain == 0) n_phase = 2;
        end else if (!bus.stall) begin
          n_reads = m_reads + 1;
          if (n_reads == m_total) begin
            if (SYS_ROWS == 1) n_phase = 2;
            else n_drain = SYS_ROWS - 1;
          end else if (n_reads % m_len == 0) n_gap = GAP;
        end
      end else begin
        n_phase = 0;
      end
      m_phase <= n_phase; m_tiles <= n_tiles; m_len <= n_len; m_total <= n_total;
      m_reads <= n_reads; m_gap <= n_gap; m_drain <= n_drain;
    end
  end

  // scoreboard: compare every cycle, away from the active edge
  always @(negedge clk) begin
    logic e_read, e_last;
    int e_tile, e_row;
    e_read = (m_phase == 1) && (m_gap == 0) && (m_reads < m_total) && !bus.stall && !bus.abort;
    e_last = e_read && (m_reads == m_total - 1);
    if (m_len == 0 || m_tiles == 0) begin
      e_tile = 0; e_row = 0;
    end else begin
      e_tile = (m_reads >= m_total) ? m_tiles - 1 : m_reads / m_len;
      e_row  = m_reads % m_len;
    end
    check("read",      32'(bus.read),      32'(e_read));
    check("last_read", 32'(bus.last_read), 32'(e_last));
    check("busy",      32'(bus.busy),      32'(m_phase != 0));
    check("done",      32'(bus.done),      32'(m_phase == 2));
    check("tile_idx",  32'(bus.tile_idx),  32'(e_tile));
    check("row_idx",   32'(bus.row_idx),   32'(e_row));
  end

  // per-cycle recordings for the directed patterns (bit c-1 = cycle c)
  logic [31:0] rd_v, last_v, done_v, busy_v;
  logic [31:0] rd0_v, last0_v, done0_v, busy0_v;
  int row_a  [32];
  int tile_a [32];
  int tile0_a[32];

  // driver: start a job, then run ncyc cycles with per-cycle stall/abort
  // masks; restart_c re-asserts start with other config mid-job
  task automatic run(input int tiles, input int len, input logic [31:0] smask,
                     input logic [31:0] amask, input int restart_c, input int ncyc);
    rd_v = '0; last_v = '0; done_v = '0; busy_v = '0;
    rd0_v = '0; last0_v = '0; done0_v = '0; busy0_v = '0;
    bus.start = 1'b1;
    bus.num_tiles = 8'(tiles);
    bus.tile_len  = 8'(len);
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      bus.stall = smask[c-1];
      bus.abort = amask[c-1];
      if (c == restart_c) begin
        bus.start = 1'b1; bus.num_tiles = 8'd5; bus.tile_len = 8'd5;
      end else begin
        bus.start = 1'b0; bus.num_tiles = 8'(tiles); bus.tile_len = 8'(len);
      end
      @(negedge clk);
      rd_v[c-1]   = bus.read;  last_v[c-1]  = bus.last_read;
      done_v[c-1] = bus.done;  busy_v[c-1]  = bus.busy;
      rd0_v[c-1]  = bus0.read; last0_v[c-1] = bus0.last_read;
      done0_v[c-1] = bus0.done; busy0_v[c-1] = bus0.busy;
      row_a[c]   = int'(bus.row_idx);
      tile_a[c]  = int'(bus.tile_idx);
      tile0_a[c] = int'(bus0.tile_idx);
      @(posedge clk); #1;
    end
    bus.stall = 1'b0; bus.abort = 1'b0; bus.start = 1'b0;
  endtask

  task automatic check_two_by_three(input string tag);
    check({tag, "_read_pattern"}, rd_v,   32'h0000_00E7);
    check({tag, "_last_read"},    last_v, 32'h0000_0080);
    check({tag, "_done_cycle"},   done_v, 32'h0000_0800);
    check({tag, "_busy_span"},    busy_v, 32'h0000_0FFF);
    check({tag, "_tile_c1"},      32'(tile_a[1]), 32'd0);
    check({tag, "_tile_c6"},      32'(tile_a[6]), 32'd1);
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.stall = 1'b0;
    bus.num_tiles = '0; bus.tile_len = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_read", 32'(bus.read), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 2 tiles x 3, gap 2, drain 3
    run(2, 3, 32'h0, 32'h0, 0, 13);
    check_two_by_three("basic");

    // stall on FEED cycles 2 and 3
    run(1, 4, 32'h6, 32'h0, 0, 11);
    check("stall_read_pattern", rd_v,   32'h0000_0039);
    check("stall_last_read",    last_v, 32'h0000_0020);
    check("stall_done_cycle",   done_v, 32'h0000_0200);
    check("stall_row_c2", 32'(row_a[2]), 32'd1);
    check("stall_row_c3", 32'(row_a[3]), 32'd1);
    check("stall_row_c6", 32'(row_a[6]), 32'd3);

    // empty jobs
    run(0, 5, 32'h0, 32'h0, 0, 3);
    check("zero_tiles_read", rd_v,   32'h0);
    check("zero_tiles_done", done_v, 32'h1);
    check("zero_tiles_busy", busy_v, 32'h1);
    run(3, 0, 32'h0, 32'h0, 0, 3);
    check("zero_len_read", rd_v,   32'h0);
    check("zero_len_done", done_v, 32'h1);
    check("zero_len_busy", busy_v, 32'h1);

    // abort on cycle 7 (second tile), then a clean job with a start while busy
    run(2, 3, 32'h0, 32'h40, 0, 9);
    check("abort_read_pattern", rd_v,   32'h0000_0027);
    check("abort_no_done",      done_v, 32'h0);
    check("abort_busy_span",    busy_v, 32'h0000_007F);
    run(2, 3, 32'h0, 32'h0, 4, 13);
    check_two_by_three("after_abort");

    // 3 tiles x 2 on the gapless, single-row instance
    run(3, 2, 32'h0, 32'h0, 0, 16);
    check("nogap_read_pattern", rd0_v,   32'h0000_003F);
    check("nogap_last_read",    last0_v, 32'h0000_0020);
    check("nogap_done_cycle",   done0_v, 32'h0000_0040);
    check("nogap_busy_span",    busy0_v, 32'h0000_007F);
    for (int c = 1; c <= 6; c++)
      check($sformatf("nogap_tile_c%0d", c), 32'(tile0_a[c]), 32'((c - 1) / 2));

    // asynchronous reset in the middle of FEED
    bus.start = 1'b1; bus.num_tiles = 8'd2; bus.tile_len = 8'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #2;
    check("pre_rst_read",    32'(bus.read),    32'd1);
    check("pre_rst_row_idx", 32'(bus.row_idx), 32'd1);
    rst = 1'b1;
    bus.start = 1'b1;
    #1;
    check("async_rst_read",  32'(bus.read),      32'd0);
    check("async_rst_busy",  32'(bus.busy),      32'd0);
    check("async_rst_done",  32'(bus.done),      32'd0);
    check("async_rst_last",  32'(bus.last_read), 32'd0);
    check("async_rst_tile",  32'(bus.tile_idx),  32'd0);
    check("async_rst_row",   32'(bus.row_idx),   32'd0);
    check("async_rst_state", 32'(bus.fsm_state), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("start_in_rst_busy", 32'(bus.busy), 32'd0);
    bus.start = 1'b0;
    #3;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("no_resume_busy", 32'(bus.busy), 32'd0);
    check("no_resume_read", 32'(bus.read), 32'd0);

    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
